seq_div_unit: RTL and testbench

Multicycle signed 32-bit restoring divider for DIV/DIVU. It sits between the div_srcA/div_srcB operand muxes (fed from A/B) and the Hi/Lo source muxes. The control unit pulses `div_start`, then waits for `div_done`. Quotient goes to Lo and remainder to Hi; a divide-by-zero flag goes to the exception logic.

---
 rtl/div_pkg.sv | 16 +
 rtl/seq_div_unit_if.sv | 37 +++
 rtl/div_restore_step.sv | 27 ++
 rtl/seq_div_unit.sv | 149 ++++++++++++++
 tb/tb_seq_div_unit.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: FSM state codes and default sizing.
// Latency: n/a (package). Backpressure: n/a.
// Ports: none. Optional feature macro DIVU_EN is consumed by the interface and top, not here.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 6;

  typedef logic [1:0] div_state_t;

  localparam div_state_t DIV_IDLE  = 2'd0;
  localparam div_state_t DIV_ITER  = 2'd1;
  localparam div_state_t DIV_FIXUP = 2'd2;
  localparam div_state_t DIV_DONE  = 2'd3;

endpackage

// File: rtl/seq_div_unit_if.sv
// Divider request/result bundle between the control unit (master) and the divider (slave).
// Latency: n/a (wiring only). Backpressure: none; the master waits for div_done.
// Signals: div_start/dividend/divisor (+ div_unsigned when DIVU_EN is defined) toward the
// divider; div_busy/div_done/div_zero/quotient/remainder back to the control and Hi/Lo muxes.
interface seq_div_unit_if #(
  parameter int WIDTH = div_pkg::DIV_WIDTH
);

  logic             div_start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
`ifdef DIVU_EN
  logic             div_unsigned;
`endif
  logic             div_busy;
  logic             div_done;
  logic             div_zero;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  modport master (
    output div_start, dividend, divisor,
`ifdef DIVU_EN
    output div_unsigned,
`endif
    input  div_busy, div_done, div_zero, quotient, remainder
  );

  modport slave (
    input  div_start, dividend, divisor,
`ifdef DIVU_EN
    input  div_unsigned,
`endif
    output div_busy, div_done, div_zero, quotient, remainder
  );

endinterface

// File: rtl/div_restore_step.sv
// One restoring-division step on unsigned magnitudes.
// Latency: combinational. Backpressure: none.
// Ports: rem (partial remainder), dvd_msb (next dividend bit), divisor (magnitude);
// next_rem (updated remainder), q_bit (quotient bit produced by this step).
module div_restore_step #(
  parameter int WIDTH = div_pkg::DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] next_rem,
  output logic             q_bit
);

  // The shifted remainder needs one extra bit: with unsigned magnitudes the divisor can
  // be up to 2^WIDTH-1, so rem < divisor can still overflow WIDTH bits after the shift.
  logic [WIDTH:0] shifted;

  always_comb begin
    shifted  = {rem, dvd_msb};
    q_bit    = (shifted >= {1'b0, divisor});
    // When the subtraction happens the true result is below divisor, so the low
    // WIDTH bits of the modular difference are exact.
    next_rem = q_bit ? (shifted[WIDTH-1:0] - divisor) : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_div_unit.sv
// Multicycle signed restoring divider (DIV; DIVU too when DIVU_EN is defined).
// Latency: done WIDTH+2 cycles after the start edge, 1 cycle for divide-by-zero.
// Backpressure: none; div_start is only sampled in IDLE and ignored otherwise.
// Ports: clk, reset (async active-low), bus (seq_div_unit_if.slave): start/operands in,
// busy/done/zero flag and quotient (to Lo) / remainder (to Hi) out.
module seq_div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic          clk,
  input  logic          reset,
  seq_div_unit_if.slave bus
);

  div_state_t       state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;    // dividend magnitude, becomes quotient magnitude
  logic [WIDTH-1:0] dsr_q, dsr_d;    // divisor magnitude
  logic [WIDTH-1:0] rem_q, rem_d;    // partial remainder
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;
  logic             zero_q, zero_d;

  logic             op_signed;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic             start_ok;

  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .dvd_msb  (dvd_q[WIDTH-1]),
    .divisor  (dsr_q),
    .next_rem (step_rem),
    .q_bit    (step_q)
  );

  // Operand conditioning. The most negative value maps onto itself, which is exactly
  // the right unsigned magnitude (2^(WIDTH-1)).
  always_comb begin
`ifdef DIVU_EN
    op_signed = !bus.div_unsigned;
`else
    op_signed = 1'b1;
`endif
    a_neg    = op_signed & bus.dividend[WIDTH-1];
    b_neg    = op_signed & bus.divisor[WIDTH-1];
    a_mag    = a_neg ? (-bus.dividend) : bus.dividend;
    b_mag    = b_neg ? (-bus.divisor) : bus.divisor;
    start_ok = (bus.divisor != '0);
  end

  // State register and datapath flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= DIV_IDLE;
      dvd_q     <= '0;
      dsr_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      quo_q     <= '0;
      rmd_q     <= '0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dvd_q     <= dvd_d;
      dsr_q     <= dsr_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      quo_q     <= quo_d;
      rmd_q     <= rmd_d;
      zero_q    <= zero_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      DIV_IDLE:  if (bus.div_start) state_d = start_ok ? DIV_ITER : DIV_DONE;
      DIV_ITER:  if (cnt_q == CNT_W'(1)) state_d = DIV_FIXUP;
      DIV_FIXUP: state_d = DIV_DONE;
      DIV_DONE:  state_d = DIV_IDLE;
      default:   state_d = DIV_IDLE;
    endcase
  end

  // Datapath next values.
  always_comb begin
    dvd_d     = dvd_q;
    dsr_d     = dsr_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    quo_d     = quo_q;
    rmd_d     = rmd_q;
    zero_d    = zero_q;
    case (state_q)
      DIV_IDLE: begin
        if (bus.div_start) begin
          if (start_ok) begin
            dvd_d     = a_mag;
            dsr_d     = b_mag;
            rem_d     = '0;
            cnt_d     = CNT_W'(WIDTH);
            neg_quo_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            zero_d    = 1'b0;
          end else begin
            // Results are left untouched so Hi/Lo keep their previous contents.
            zero_d = 1'b1;
          end
        end
      end
      DIV_ITER: begin
        rem_d = step_rem;
        dvd_d = {dvd_q[WIDTH-2:0], step_q};
        cnt_d = cnt_q - CNT_W'(1);
      end
      DIV_FIXUP: begin
        // Truncating division: remainder follows the dividend's sign. The overflow
        // case (most negative / -1) wraps back to the most negative value.
        quo_d = neg_quo_q ? (-dvd_q) : dvd_q;
        rmd_d = neg_rem_q ? (-rem_q) : rem_q;
      end
      default: ;
    endcase
  end

  // Output logic. busy drops in DONE so a back-to-back start from IDLE is legal.
  always_comb begin
    bus.div_busy  = (state_q == DIV_ITER) || (state_q == DIV_FIXUP);
    bus.div_done  = (state_q == DIV_DONE);
    bus.div_zero  = zero_q;
    bus.quotient  = quo_q;
    bus.remainder = rmd_q;
  end

endmodule

// File: tb/tb_seq_div_unit.sv
module tb_seq_div_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seq_div_unit_if #(.WIDTH(32)) bus ();

  seq_div_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference state: last architecturally visible results (held across divide-by-zero).
  logic [31:0] mq = '0;
  logic [31:0] mr = '0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
    int          lat;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: plain wide arithmetic, truncating toward zero.
  task automatic model(input logic [31:0] a, input logic [31:0] b, input bit uns,
                       output logic [31:0] q, output logic [31:0] r, output logic z);
    longint sa, sb, lq, lr;
    if (b == 0) begin
      z = 1'b1; q = mq; r = mr;
    end else begin
      z = 1'b0;
      if (uns) begin
        sa = longint'({32'd0, a}); sb = longint'({32'd0, b});
      end else begin
        sa = longint'($signed(a)); sb = longint'($signed(b));
      end
      lq = sa / sb;
      lr = sa % sb;
      q = lq[31:0];
      r = lr[31:0];
      mq = q; mr = r;
    end
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input bit uns);
    bus.dividend  = a;
    bus.divisor   = b;
`ifdef DIVU_EN
    bus.div_unsigned = uns;
`else
    if (uns) $display("note: unsigned request issued in signed-only build");
`endif
    bus.div_start = 1'b1;
    @(posedge clk); #1;
    bus.div_start = 1'b0;
  endtask

  // lat counts clock edges from the start edge (inclusive) to the one that raised done.
  task automatic wait_done(input int from, output int lat);
    lat = from;
    while (bus.div_done !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 200) begin
      errors++;
      $display("FAIL timeout: div_done never rose, got 0 expected 1");
    end
  endtask

  task automatic finish_op(input string tag, input logic [31:0] q, input logic [31:0] r,
                           input logic z, input int exp_lat, input int lat);
    check({tag, ".quotient"}, bus.quotient, q);
    check({tag, ".remainder"}, bus.remainder, r);
    check({tag, ".zero"}, {31'd0, bus.div_zero}, {31'd0, z});
    check({tag, ".latency"}, lat, exp_lat);
    @(posedge clk); #1;
    check({tag, ".done_pulse"}, {31'd0, bus.div_done}, 32'd0);
  endtask

  task automatic run_model_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                              input bit uns);
    logic [31:0] q, r;
    logic        z;
    int          lat;
    model(a, b, uns, q, r, z);
    start_op(a, b, uns);
    check({tag, ".busy"}, {31'd0, bus.div_busy}, {31'd0, (b != 0)});
    wait_done(1, lat);
    finish_op(tag, q, r, z, z ? 1 : 34, lat);
  endtask

  initial begin
    int lat;
    bus.div_start = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
`ifdef DIVU_EN
    bus.div_unsigned = 1'b0;
`endif
    reset = 1'b0;
    #12;
    check("rst.quotient", bus.quotient, 32'd0);
    check("rst.remainder", bus.remainder, 32'd0);
    check("rst.busy", {31'd0, bus.div_busy}, 32'd0);
    check("rst.done", {31'd0, bus.div_done}, 32'd0);
    check("rst.zero", {31'd0, bus.div_zero}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Directed table; expected values written out by hand.
    tbl[0] = '{32'd7,        32'd2,        32'd3,        32'd1,        1'b0, 34};
    tbl[1] = '{32'd5,        32'd0,        32'd3,        32'd1,        1'b1, 1};
    tbl[2] = '{32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 34};
    tbl[3] = '{32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0, 34};
    tbl[4] = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0, 34};
    tbl[5] = '{32'd0,        32'd5,        32'd0,        32'd0,        1'b0, 34};
    tbl[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 34};
    tbl[7] = '{32'h80000000, 32'h80000000, 32'd1,        32'd0,        1'b0, 34};
    tbl[8] = '{32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 34};
    tbl[9] = '{32'h7FFFFFFF, 32'h80000000, 32'd0,        32'h7FFFFFFF, 1'b0, 34};

    for (int i = 0; i < 10; i++) begin
      start_op(tbl[i].a, tbl[i].b, 1'b0);
      check($sformatf("vec%0d.busy", i), {31'd0, bus.div_busy}, {31'd0, !tbl[i].z});
      wait_done(1, lat);
      finish_op($sformatf("vec%0d", i), tbl[i].q, tbl[i].r, tbl[i].z, tbl[i].lat, lat);
      if (!tbl[i].z) begin
        mq = tbl[i].q; mr = tbl[i].r;
      end
    end

    // Back-to-back: start again in the IDLE cycle right after done.
    start_op(32'd9, 32'd3, 1'b0);
    wait_done(1, lat);
    finish_op("b2b_first", 32'd3, 32'd0, 1'b0, 34, lat);
    start_op(32'd20, 32'd6, 1'b0);
    wait_done(1, lat);
    finish_op("b2b_second", 32'd3, 32'd2, 1'b0, 34, lat);

    // A second start in mid-operation must be ignored.
    start_op(32'd100, 32'd7, 1'b0);
    repeat (8) begin @(posedge clk); #1; end
    bus.dividend  = 32'd9;
    bus.divisor   = 32'd3;
    bus.div_start = 1'b1;
    @(posedge clk); #1;
    bus.div_start = 1'b0;
    wait_done(10, lat);
    finish_op("restart_ignored", 32'd14, 32'd2, 1'b0, 34, lat);

    // Asynchronous reset in the middle of an operation.
    start_op(32'd100, 32'd7, 1'b0);
    repeat (13) begin @(posedge clk); #1; end
    #2 reset = 1'b0;
    #1;
    check("midrst.quotient", bus.quotient, 32'd0);
    check("midrst.remainder", bus.remainder, 32'd0);
    check("midrst.busy", {31'd0, bus.div_busy}, 32'd0);
    check("midrst.done", {31'd0, bus.div_done}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    mq = '0; mr = '0;
    repeat (3) begin @(posedge clk); #1; end
    check("midrst.idle_no_done", {31'd0, bus.div_done}, 32'd0);
    check("midrst.idle_no_busy", {31'd0, bus.div_busy}, 32'd0);
    start_op(32'd9, 32'd3, 1'b0);
    wait_done(1, lat);
    finish_op("after_rst", 32'd3, 32'd0, 1'b0, 34, lat);
    mq = 32'd3; mr = 32'd0;

    // Randomized operands against the behavioural model.
    for (int n = 0; n < 50; n++) begin
      logic [31:0] a, b;
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: b = -($urandom_range(1, 300));
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(0, 31);
      run_model_op($sformatf("rnd%0d", n), a, b, 1'b0);
    end

`ifdef DIVU_EN
    run_model_op("divu_ex", 32'hFFFFFFFE, 32'd2, 1'b1);
    check("divu_ex.q_const", bus.quotient, 32'h7FFFFFFF);
    for (int n = 0; n < 10; n++) begin
      run_model_op($sformatf("divu%0d", n), $urandom, $urandom_range(1, 32'hFFFFFFFF), 1'b1);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
